score_bcd_to_bin: RTL and testbench



---
 rtl/score_pkg.sv | 20 ++
 rtl/bcd_mac10.sv | 22 ++
 rtl/score_bcd_to_bin.sv | 116 +++++++++++
 tb/tb_score_bcd_to_bin.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared score-path constants and types, used by the BCD converter and the
// binary-to-digit display logic.
package score_pkg;

  localparam int unsigned SCORE_W    = 17;
  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned BCD_W      = 4;

  // Display-side constants shared with the binary-to-digit path
  localparam int unsigned DEC_BASE   = 10;
  localparam int unsigned DIGIT_MAX  = 9;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// One decimal fold step: acc*10 + digit, plus a flag for non-decimal digits.
module bcd_mac10 #(
  parameter int unsigned SCORE_W = score_pkg::SCORE_W
) (
  input  logic [SCORE_W-1:0] acc,
  input  logic [3:0]         digit,
  output logic [SCORE_W-1:0] acc_next,
  output logic               digit_bad
);

  logic [SCORE_W-1:0] acc_x8;
  logic [SCORE_W-1:0] acc_x2;

  // Shift-add multiply by ten; wrap is harmless because bad results are discarded
  always_comb begin
    acc_x8    = acc << 3;
    acc_x2    = acc << 1;
    acc_next  = acc_x8 + acc_x2 + SCORE_W'(digit);
    digit_bad = (digit > 4'd9);
  end

endmodule

// File: rtl/score_bcd_to_bin.sv
// Sequential BCD-to-binary converter: folds packed digits MSD-first, one per
// clock, behind a start/busy handshake with a one-cycle done pulse.
module score_bcd_to_bin #(
  parameter int unsigned NUM_DIGITS = score_pkg::NUM_DIGITS,
  parameter int unsigned SCORE_W    = score_pkg::SCORE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [SCORE_W-1:0]      score,
  output logic                    err
);
  import score_pkg::*;

  localparam int unsigned IN_W  = BCD_W * NUM_DIGITS;
  localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               capture;
  logic               step;
  logic               last;

  logic [IN_W-1:0]    sreg;
  logic [SCORE_W-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               err_sticky;

  logic [SCORE_W-1:0] acc_next;
  logic               digit_bad;
  logic               err_any;

  bcd_mac10 #(
    .SCORE_W (SCORE_W)
  ) u_mac10 (
    .acc       (acc),
    .digit     (sreg[IN_W-1 -: BCD_W]),
    .acc_next  (acc_next),
    .digit_bad (digit_bad)
  );

  assign err_any = err_sticky | digit_bad;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = CONV;
          capture   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
          state_nxt = DONE;
          last      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      acc        <= '0;
      cnt        <= '0;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      score      <= '0;
      err        <= 1'b0;
    end else begin
      busy <= (state_nxt == CONV);
      done <= (state_nxt == DONE);
      if (capture) begin
        sreg       <= bcd_in;
        acc        <= '0;
        cnt        <= '0;
        err_sticky <= 1'b0;
      end else if (step) begin
        acc  <= acc_next;
        sreg <= sreg << BCD_W;
        cnt  <= cnt + CNT_W'(1);
        if (digit_bad) begin
          err_sticky <= 1'b1;
        end
        if (last) begin
          score <= err_any ? '0 : acc_next;
          err   <= err_any;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_to_bin.sv
// Self-checking bench for score_bcd_to_bin: vector table, handshake corner
// sequences, and randomized back-to-back conversions against a decimal model.
module tb_score_bcd_to_bin;

  localparam int unsigned ND = 5;
  localparam int unsigned SW = 17;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4*ND-1:0] bcd_in;
  logic          busy;
  logic          done;
  logic [SW-1:0] score;
  logic          err;

  int n_pass;
  int n_total;

  typedef struct {
    logic [19:0] bcd;
    int          exp_score;
    logic        exp_err;
  } vec_t;

  score_bcd_to_bin dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .score  (score),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Positional decimal value of a packed BCD word; any nibble > 9 is an error
  function automatic void ref_convert(input logic [19:0] bcd, output int val, output logic bad);
    int pow;
    logic [19:0] w;
    w   = bcd;
    val = 0;
    bad = 1'b0;
    pow = 1;
    for (int i = 0; i < ND; i++) begin
      if (w[3:0] > 4'd9) bad = 1'b1;
      val = val + int'(w[3:0]) * pow;
      pow = pow * 10;
      w   = w >> 4;
    end
    if (bad) val = 0;
  endfunction

  function automatic logic [19:0] rand_bcd();
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r = (r << 4) | 20'($urandom_range(0, 9));
    return r;
  endfunction

  // Single conversion from IDLE: start in cycle 0, busy 1..5, done in 6, idle in 7
  task automatic run_conv(input string name, input logic [19:0] bcd, input int exp_score, input logic exp_err);
    bcd_in = bcd;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bcd_in = ~bcd;
    for (int c = 1; c <= ND; c++) begin
      check({name, "_busy"}, int'(busy), 1);
      check({name, "_nodone"}, int'(done), 0);
      if (c < ND) tick();
      else tick();
    end
    check({name, "_done"}, int'(done), 1);
    check({name, "_busy6"}, int'(busy), 0);
    check({name, "_score"}, int'(score), exp_score);
    check({name, "_err"}, int'(err), int'(exp_err));
    tick();
    check({name, "_done_once"}, int'(done), 0);
    check({name, "_held"}, int'(score), exp_score);
  endtask

  vec_t vecs[$];
  int   rvals[$];
  int   rv;
  logic rbad;
  logic [19:0] rb;
  int   k;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    bcd_in  = '0;

    vecs.push_back('{20'h12345, 12345, 1'b0});
    vecs.push_back('{20'h99999, 99999, 1'b0});
    vecs.push_back('{20'h00000, 0,     1'b0});
    vecs.push_back('{20'h12A45, 0,     1'b1});
    vecs.push_back('{20'h00007, 7,     1'b0});
    vecs.push_back('{20'hF0000, 0,     1'b1});
    vecs.push_back('{20'h10000, 10000, 1'b0});
    vecs.push_back('{20'h9999F, 0,     1'b1});
    vecs.push_back('{20'h90909, 90909, 1'b0});

    // Reset values
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_score", int'(score), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_score, vecs[i].exp_err);
    end

    // Start held high with changing bcd_in: first result unaffected, DONE-cycle start accepted
    bcd_in = 20'h11111;
    start  = 1'b1;
    tick();
    bcd_in = 20'h22222;
    for (int c = 1; c <= ND; c++) begin
      check("hold_busy", int'(busy), 1);
      tick();
    end
    check("hold_done1", int'(done), 1);
    check("hold_score1", int'(score), 11111);
    tick();
    start  = 1'b0;
    bcd_in = 20'h33333;
    check("hold_rebusy", int'(busy), 1);
    check("hold_nodone", int'(done), 0);
    for (int c = 2; c <= ND; c++) tick();
    tick();
    check("hold_done2", int'(done), 1);
    check("hold_score2", int'(score), 22222);
    tick();

    // Asynchronous reset mid-conversion
    bcd_in = 20'h12345;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    check("mid_busy_pre", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_score", int'(score), 0);
    check("arst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      check("arst_no_done", int'(done), 0);
      check("arst_idle", int'(busy), 0);
      tick();
    end
    run_conv("post_rst", 20'h00042, 42, 1'b0);

    // Random back-to-back conversions with start held through each DONE cycle
    rb = rand_bcd();
    ref_convert(rb, rv, rbad);
    rvals.push_back(rv);
    bcd_in = rb;
    start  = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) begin
      rb = rand_bcd();
      bcd_in = rb;
      k = 0;
      while (!done && k < 10) begin
        tick();
        k++;
      end
      check("rand_done_seen", int'(done), 1);
      check("rand_latency", k, ND);
      check("rand_score", int'(score), rvals.pop_front());
      check("rand_err", int'(err), 0);
      if (i < 999) begin
        ref_convert(rb, rv, rbad);
        rvals.push_back(rv);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      check("rand_tail_no_done", int'(done), 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
